// File: rtl/im_boot_loader.sv
// Byte-stream boot loader: parses a 2-byte word count, packs big-endian words, writes them to instruction memory.
// Holds the CPU until the image is fully written; reports oversize images and stalled streams as errors.
module im_boot_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h00003000,
    parameter int          DEPTH          = 1024,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        im_we,
    output logic [31:0] im_waddr,
    output logic [31:0] im_wdata,
    output logic [10:0] word_count,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        err
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {HDR0, HDR1, CHECK, DATA, FIN, DONE, ERR} state_t;

    state_t        state, state_nxt;
    logic [15:0]   n;
    logic [23:0]   shreg;
    logic [1:0]    byte_idx;
    logic [IW-1:0] idle;
    logic          accept;
    logic          last_word;
    logic          timed_out;
    logic          idle_state;

    always_comb begin
        byte_ready = (state == HDR0) || (state == HDR1) || (state == DATA);
        accept     = byte_valid && byte_ready;
        idle_state = (state == HDR1) || (state == DATA);
        // The counter would reach TIMEOUT_CYCLES on this edge.
        timed_out  = idle_state && !accept && (idle == IW'(TIMEOUT_CYCLES - 1));
        last_word  = ({5'd0, word_count} + 16'd1) == n;
        state_nxt  = state;
        case (state)
            HDR0:  if (accept) state_nxt = HDR1;
            HDR1: begin
                if (accept)         state_nxt = CHECK;
                else if (timed_out) state_nxt = ERR;
            end
            CHECK: begin
                if ({16'd0, n} > 32'(DEPTH)) state_nxt = ERR;
                else if (n == 16'd0)         state_nxt = FIN;
                else                         state_nxt = DATA;
            end
            DATA: begin
                if (accept && byte_idx == 2'd3 && last_word) state_nxt = FIN;
                else if (timed_out)                          state_nxt = ERR;
            end
            FIN:       state_nxt = DONE;
            DONE, ERR: if (start) state_nxt = HDR0;
            default:   state_nxt = HDR0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HDR0;
            n          <= 16'd0;
            shreg      <= 24'd0;
            byte_idx   <= 2'd0;
            idle       <= '0;
            im_we      <= 1'b0;
            im_waddr   <= BASE_ADDR;
            im_wdata   <= 32'd0;
            word_count <= 11'd0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            im_we <= 1'b0;
            if (idle_state && !accept) idle <= idle + 1'b1;
            else                       idle <= '0;

            case (state)
                HDR0: if (accept) n <= {byte_data, 8'd0};
                HDR1: if (accept) n[7:0] <= byte_data;
                DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            im_we      <= 1'b1;
                            im_wdata   <= {shreg, byte_data};
                            im_waddr   <= BASE_ADDR + {19'd0, word_count, 2'b00};
                            word_count <= word_count + 11'd1;
                        end else begin
                            shreg <= {shreg[15:0], byte_data};
                        end
                    end
                end
                FIN: begin
                    load_done <= 1'b1;
                    cpu_hold  <= 1'b0;
                end
                DONE, ERR: begin
                    if (start) begin
                        load_done  <= 1'b0;
                        err        <= 1'b0;
                        word_count <= 11'd0;
                        byte_idx   <= 2'd0;
                        cpu_hold   <= 1'b1;
                        im_waddr   <= BASE_ADDR;
                    end
                end
                default: ;
            endcase

            // Entering ERR drops any half-assembled word.
            if (state_nxt == ERR && state != ERR) begin
                err       <= 1'b1;
                cpu_hold  <= 1'b1;
                load_done <= 1'b0;
                byte_idx  <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_im_boot_loader.sv
module tb_im_boot_loader;

    localparam logic [31:0] BASE = 32'h00003000;

    logic        clk = 1'b0;
    logic        reset, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, im_we, cpu_hold, load_done, err;
    logic [31:0] im_waddr, im_wdata;
    logic [10:0] word_count;

    int tests = 0;
    int fails = 0;

    im_boot_loader #(.BASE_ADDR(BASE), .DEPTH(1024), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .im_we(im_we),
        .im_waddr(im_waddr), .im_wdata(im_wdata), .word_count(word_count),
        .cpu_hold(cpu_hold), .load_done(load_done), .err(err)
    );

    always #5 clk = ~clk;

    // Write log, owned by this monitor only.
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    bit          wh[$];
    int          wc[$];
    int          cyc = 0;
    int          done_cyc = 0;
    logic        prev_done = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (im_we) begin
            wa.push_back(im_waddr);
            wd.push_back(im_wdata);
            wh.push_back(cpu_hold && !load_done);
            wc.push_back(cyc);
        end
        if (load_done && !prev_done) done_cyc = cyc;
        prev_done = load_done;
    end

    typedef struct {
        logic [15:0]      n;
        logic [3:0][31:0] w;
        bit               gaps;
        bit               exp_err;
        bit               exp_done;
        int               exp_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [15:0] n, input logic [31:0] w0, w1, w2, w3,
                       input bit gaps, input bit e, input bit d, input int c);
        vec_t v;
        v.n = n; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.gaps = gaps; v.exp_err = e; v.exp_done = d; v.exp_cnt = c;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("byte_ready_wait", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 3; k >= 0; k--) begin
            if (gaps) repeat ($urandom_range(0, 5)) @(negedge clk);
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(load_done || err) && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_byte_ready", 32'(byte_ready), 32'd1);
        chk("rst_im_we",      32'(im_we),      32'd0);
        chk("rst_im_waddr",   im_waddr,        BASE);
        chk("rst_im_wdata",   im_wdata,        32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_cpu_hold",   32'(cpu_hold),   32'd1);
        chk("rst_load_done",  32'(load_done),  32'd0);
        chk("rst_err",        32'(err),        32'd0);

        add(16'd2,    32'h24080005, 32'h0000000C, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 2);
        add(16'd0,    32'h0, 32'h0, 32'h0, 32'h0,                1'b0, 1'b0, 1'b1, 0);
        add(16'd1025, 32'h0, 32'h0, 32'h0, 32'h0,                1'b0, 1'b1, 1'b0, 0);
        add(16'd4,    32'h8C220000, 32'hAC430004, 32'h1000FFFF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 4);
        add(16'd1,    32'hCAFEF00D, 32'h0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b1, 1);
        add(16'd4,    32'h8C220000, 32'hAC430004, 32'h1000FFFF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 4);

        foreach (tbl[i]) begin
            if (i > 0) begin
                pulse_start();
                chk($sformatf("v%0d_start_ready", i), 32'(byte_ready), 32'd1);
                chk($sformatf("v%0d_start_err", i),   32'(err),        32'd0);
                chk($sformatf("v%0d_start_done", i),  32'(load_done),  32'd0);
                chk($sformatf("v%0d_start_hold", i),  32'(cpu_hold),   32'd1);
                chk($sformatf("v%0d_start_wc", i),    32'(word_count), 32'd0);
            end
            base = wa.size();
            send_byte(tbl[i].n[15:8]);
            if (tbl[i].gaps) repeat (3) @(negedge clk);
            send_byte(tbl[i].n[7:0]);
            if (!tbl[i].exp_err)
                for (int j = 0; j < int'(tbl[i].n); j++) send_word(tbl[i].w[j], tbl[i].gaps);
            wait_end();
            chk($sformatf("v%0d_err", i),        32'(err),        32'(tbl[i].exp_err));
            chk($sformatf("v%0d_done", i),       32'(load_done),  32'(tbl[i].exp_done));
            chk($sformatf("v%0d_hold", i),       32'(cpu_hold),   32'(!tbl[i].exp_done));
            chk($sformatf("v%0d_count", i),      32'(word_count), 32'(tbl[i].exp_cnt));
            chk($sformatf("v%0d_ready", i),      32'(byte_ready), 32'd0);
            chk($sformatf("v%0d_nwrites", i),    32'(wa.size() - base), 32'(tbl[i].exp_cnt));
            for (int j = 0; j < tbl[i].exp_cnt && base + j < wa.size(); j++) begin
                chk($sformatf("v%0d_addr%0d", i, j), wa[base+j], BASE + 32'(4*j));
                chk($sformatf("v%0d_data%0d", i, j), wd[base+j], tbl[i].w[j]);
                chk($sformatf("v%0d_hold%0d", i, j), 32'(wh[base+j]), 32'd1);
            end
            if (tbl[i].exp_cnt > 0 && wa.size() > base) begin
                tests++;
                if (done_cyc - wc[wc.size()-1] < 1 || done_cyc - wc[wc.size()-1] > 2) begin
                    fails++;
                    $display("FAIL v%0d_done_delay: got %0d cycles expected 1..2", i, done_cyc - wc[wc.size()-1]);
                end
            end
        end

        // Stalled stream mid-word: error exactly on the 16th idle cycle.
        pulse_start();
        base = wa.size();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        repeat (15) @(negedge clk);
        chk("to_err_before", 32'(err), 32'd0);
        @(negedge clk);
        chk("to_err",     32'(err),      32'd1);
        chk("to_hold",    32'(cpu_hold), 32'd1);
        chk("to_ready",   32'(byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("to_nwrites", 32'(wa.size() - base), 32'd0);

        // Idle line before the header never times out.
        pulse_start();
        repeat (1000) @(negedge clk);
        chk("hdr0_idle_err",   32'(err),        32'd0);
        chk("hdr0_idle_ready", 32'(byte_ready), 32'd1);

        // Reset in the middle of a load, then a fresh one-word image.
        send_byte(8'h00); send_byte(8'h03);
        send_word(32'h01020304, 1'b0);
        send_byte(8'h05); send_byte(8'h06);
        chk("mid_count", 32'(word_count), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_count", 32'(word_count), 32'd0);
        chk("mid_rst_addr",  im_waddr,        BASE);
        chk("mid_rst_hold",  32'(cpu_hold),   32'd1);
        base = wa.size();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_end();
        chk("mid_nwrites", 32'(wa.size() - base), 32'd1);
        if (wa.size() > base) begin
            chk("mid_addr", wa[base], BASE);
            chk("mid_data", wd[base], 32'h11223344);
        end
        chk("mid_count2", 32'(word_count), 32'd1);
        chk("mid_done",   32'(load_done),  32'd1);
        chk("mid_hold2",  32'(cpu_hold),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
